// File: rtl/fpu_regfile_pkg.sv
// Shared opcode encodings, controller state type and opcode classification
// for the FPU register-file front end.
package fpu_regfile_pkg;

    // Opcodes executed locally by the controller
    localparam logic [5:0] OP_LOADI  = 6'b111001;
    localparam logic [5:0] OP_STORE  = 6'b111000;

    // Compare class: op[5:4] == 2'b01, result is the flag only
    localparam logic [5:0] CMP_MASK  = 6'b110000;
    localparam logic [5:0] CMP_CLASS = 6'b010000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_WAIT,
        S_RESP
    } state_t;

    function automatic logic is_compare(input logic [5:0] op);
        return (op & CMP_MASK) == CMP_CLASS;
    endfunction

    function automatic logic is_local(input logic [5:0] op);
        return (op == OP_LOADI) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/fpu_regfile_mem.sv
// NREG x W register storage: two asynchronous read ports, one synchronous
// write port, asynchronous clear of every entry.
module fpu_regfile_mem
    import fpu_regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int W    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [W-1:0]            rdata_a,
    output logic [W-1:0]            rdata_b,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [W-1:0]            wdata
);

    logic [W-1:0] regs [NREG];

    // Storage update: clear all entries on reset, otherwise single write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Asynchronous read ports
    always_comb begin
        rdata_a = regs[raddr_a];
        rdata_b = regs[raddr_b];
    end

endmodule

// File: rtl/fpu_regfile_ctrl.sv
// Register-file front end for the FPU: accepts one command at a time,
// executes LOADI/STORE locally, dispatches everything else to an external
// execution unit, writes results back and returns a response. A watchdog
// bounds the wait for the execution unit's result. Requires OPW >= 6.
module fpu_regfile_ctrl
    import fpu_regfile_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int W       = 32,
    parameter int OPW     = 6,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPW-1:0]          op,
    input  logic [$clog2(NREG)-1:0] x1,
    input  logic [$clog2(NREG)-1:0] x2,
    input  logic [$clog2(NREG)-1:0] y,
    input  logic [W-1:0]            in_data,
    output logic                    exe_valid,
    input  logic                    exe_ready,
    output logic [OPW-1:0]          exe_op,
    output logic [W-1:0]            exe_a,
    output logic [W-1:0]            exe_b,
    input  logic                    exe_done,
    input  logic [W-1:0]            exe_result,
    input  logic                    exe_flag,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [W-1:0]            out_data,
    output logic                    out_flag,
    output logic                    err
);

    localparam int AW = $clog2(NREG);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

    state_t state;
    state_t state_next;

    logic [5:0]    op6;
    logic          accept;
    logic          done_take;
    logic          timeout_hit;
    logic [CW-1:0] wd_cnt;
    logic [AW-1:0] y_q;
    logic          arith_q;

    logic [W-1:0]  rd_a;
    logic [W-1:0]  rd_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    fpu_regfile_mem #(
        .NREG (NREG),
        .W    (W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (x1),
        .raddr_b (x2),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we      (wr_en),
        .waddr   (wr_addr),
        .wdata   (wr_data)
    );

    // Handshake qualifiers shared by the FSM, datapath and write port
    always_comb begin
        op6         = op[5:0];
        accept      = req_valid && req_ready;
        done_take   = exe_done && (((state == S_DISPATCH) && exe_ready) ||
                                   (state == S_WAIT));
        timeout_hit = (state == S_WAIT) && !exe_done && (wd_cnt == WD_LAST);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = is_local(op6) ? S_RESP : S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (exe_ready) begin
                    state_next = exe_done ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (exe_done || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs; req_ready is masked while reset is held
    always_comb begin
        req_ready  = (state == S_IDLE) && !rst;
        exe_valid  = (state == S_DISPATCH);
        resp_valid = (state == S_RESP);
    end

    // Register-file write port: LOADI on accept, arithmetic result on done
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = y;
        wr_data = in_data;
        if ((state == S_IDLE) && accept && (op6 == OP_LOADI)) begin
            wr_en = 1'b1;
        end else if (done_take && arith_q) begin
            wr_en   = 1'b1;
            wr_addr = y_q;
            wr_data = exe_result;
        end
    end

    // Operand/response datapath and watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_op   <= '0;
            exe_a    <= '0;
            exe_b    <= '0;
            y_q      <= '0;
            arith_q  <= 1'b0;
            out_data <= '0;
            out_flag <= 1'b0;
            err      <= 1'b0;
            wd_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op6 == OP_LOADI) begin
                            out_data <= in_data;
                        end else if (op6 == OP_STORE) begin
                            out_data <= rd_a;
                        end else begin
                            exe_op  <= op;
                            exe_a   <= rd_a;
                            exe_b   <= rd_b;
                            y_q     <= y;
                            arith_q <= !is_compare(op6);
                        end
                    end
                end
                S_DISPATCH: begin
                    if (exe_ready) begin
                        wd_cnt <= '0;
                    end
                    if (done_take) begin
                        out_data <= exe_result;
                        out_flag <= exe_flag;
                    end
                end
                S_WAIT: begin
                    if (done_take) begin
                        out_data <= exe_result;
                        out_flag <= exe_flag;
                    end else if (timeout_hit) begin
                        err      <= 1'b1;
                        out_data <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        err      <= 1'b0;
                        out_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_regfile_ctrl.sv
// Directed self-checking bench for fpu_regfile_ctrl (TIMEOUT = 8).
module tb_fpu_regfile_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] in_data;
    logic        exe_valid;
    logic        exe_ready;
    logic [5:0]  exe_op;
    logic [31:0] exe_a;
    logic [31:0] exe_b;
    logic        exe_done;
    logic [31:0] exe_result;
    logic        exe_flag;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] out_data;
    logic        out_flag;
    logic        err;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [5:0] LOADI = 6'b111001;
    localparam logic [5:0] STORE = 6'b111000;

    fpu_regfile_ctrl #(
        .NREG    (32),
        .W       (32),
        .OPW     (6),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .x1         (x1),
        .x2         (x2),
        .y          (y),
        .in_data    (in_data),
        .exe_valid  (exe_valid),
        .exe_ready  (exe_ready),
        .exe_op     (exe_op),
        .exe_a      (exe_a),
        .exe_b      (exe_b),
        .exe_done   (exe_done),
        .exe_result (exe_result),
        .exe_flag   (exe_flag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out_data   (out_data),
        .out_flag   (out_flag),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present a request for exactly one edge (controller must be in IDLE)
    task automatic issue(input logic [5:0] o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [31:0] imm);
        op        = o;
        x1        = a;
        x2        = b;
        y         = d;
        in_data   = imm;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    // consume the pending response
    task automatic take_resp(input string tag);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check({tag, "_resp_valid_low"}, 32'(resp_valid), 32'd0);
        check({tag, "_req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        op         = '0;
        x1         = '0;
        x2         = '0;
        y          = '0;
        in_data    = '0;
        exe_ready  = 1'b0;
        exe_done   = 1'b0;
        exe_result = '0;
        exe_flag   = 1'b0;
        resp_ready = 1'b0;

        // reset state
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_exe_valid", 32'(exe_valid), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_flag", 32'(out_flag), 32'd0);
        check("rst_exe_a", exe_a, 32'd0);
        check("rst_exe_op", 32'(exe_op), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // LOADI r2 = c0490fcf, response one cycle after accept
        issue(LOADI, 5'd0, 5'd0, 5'd2, 32'hc0490fcf);
        check("ldi_resp_valid", 32'(resp_valid), 32'd1);
        check("ldi_out_data", out_data, 32'hc0490fcf);
        check("ldi_err", 32'(err), 32'd0);
        check("ldi_req_ready", 32'(req_ready), 32'd0);
        take_resp("ldi");
        issue(STORE, 5'd2, 5'd0, 5'd0, 32'h0);
        check("st2_resp_valid", 32'(resp_valid), 32'd1);
        check("st2_out_data", out_data, 32'hc0490fcf);
        take_resp("st2");

        // r0 = 43, r1 = 14, then add r2 = r1 + r0
        issue(LOADI, 5'd0, 5'd0, 5'd0, 32'd43);
        take_resp("ld0");
        issue(LOADI, 5'd0, 5'd0, 5'd1, 32'd14);
        take_resp("ld1");
        issue(6'b000001, 5'd1, 5'd0, 5'd2, 32'h0);
        check("add_exe_valid", 32'(exe_valid), 32'd1);
        check("add_exe_a", exe_a, 32'd14);
        check("add_exe_b", exe_b, 32'd43);
        check("add_exe_op", 32'(exe_op), 32'd1);
        check("add_resp_valid_early", 32'(resp_valid), 32'd0);
        exe_ready  = 1'b1;
        exe_done   = 1'b1;
        exe_result = 32'd57;
        step();
        exe_ready  = 1'b0;
        exe_done   = 1'b0;
        check("add_resp_valid", 32'(resp_valid), 32'd1);
        check("add_out_data", out_data, 32'd57);
        check("add_exe_valid_low", 32'(exe_valid), 32'd0);
        check("add_err", 32'(err), 32'd0);
        take_resp("add");
        issue(STORE, 5'd2, 5'd0, 5'd0, 32'h0);
        check("st_add_out_data", out_data, 32'd57);
        take_resp("st_add");

        // compare r0 < r1 (43 < 14 -> 0), exe_ready held off 5 cycles
        issue(6'b010000, 5'd0, 5'd1, 5'd2, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check("cmp_hold_valid", 32'(exe_valid), 32'd1);
            check("cmp_hold_a", exe_a, 32'd43);
            check("cmp_hold_b", exe_b, 32'd14);
            check("cmp_hold_op", 32'(exe_op), 32'h10);
            step();
        end
        exe_ready = 1'b1;
        step();
        exe_ready = 1'b0;
        check("cmp_wait_exe_valid", 32'(exe_valid), 32'd0);
        check("cmp_wait_resp_valid", 32'(resp_valid), 32'd0);
        exe_done   = 1'b1;
        exe_result = 32'h0000_0001;
        exe_flag   = 1'b0;
        step();
        exe_done = 1'b0;
        check("cmp_resp_valid", 32'(resp_valid), 32'd1);
        check("cmp_out_flag", 32'(out_flag), 32'd0);
        check("cmp_out_data", out_data, 32'h0000_0001);

        // response backpressure with a LOADI r3 = 55 already waiting
        op        = LOADI;
        y         = 5'd3;
        in_data   = 32'h55;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_out_data", out_data, 32'h0000_0001);
            check("bp_err", 32'(err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("bp_after_hs_resp_valid", 32'(resp_valid), 32'd0);
        check("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        check("bp_next_resp_valid", 32'(resp_valid), 32'd1);
        check("bp_next_out_data", out_data, 32'h55);
        take_resp("bp_next");
        issue(STORE, 5'd2, 5'd0, 5'd0, 32'h0);
        check("cmp_no_write", out_data, 32'd57);
        take_resp("cmp_no_write");

        // compare r1 < r0 (14 < 43 -> 1), flag cleared by the handshake
        issue(6'b010000, 5'd1, 5'd0, 5'd5, 32'h0);
        exe_ready  = 1'b1;
        exe_done   = 1'b1;
        exe_result = 32'h0;
        exe_flag   = 1'b1;
        step();
        exe_ready = 1'b0;
        exe_done  = 1'b0;
        exe_flag  = 1'b0;
        check("cmp2_out_flag", 32'(out_flag), 32'd1);
        take_resp("cmp2");
        check("cmp2_flag_cleared", 32'(out_flag), 32'd0);

        // watchdog: r4 = 1234, then an op whose result never arrives
        issue(LOADI, 5'd0, 5'd0, 5'd4, 32'h1234);
        take_resp("ld4");
        issue(6'b000010, 5'd0, 5'd1, 5'd4, 32'h0);
        exe_ready = 1'b1;
        step();
        exe_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            check("to_pending", 32'(resp_valid), 32'd0);
        end
        step();
        check("to_resp_valid", 32'(resp_valid), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_out_data", out_data, 32'd0);
        exe_done   = 1'b1;
        exe_result = 32'h99;
        exe_flag   = 1'b1;
        step();
        exe_done = 1'b0;
        exe_flag = 1'b0;
        check("to_late_done_data", out_data, 32'd0);
        check("to_late_done_err", 32'(err), 32'd1);
        check("to_late_done_flag", 32'(out_flag), 32'd0);
        take_resp("to");
        check("to_err_cleared", 32'(err), 32'd0);
        exe_done = 1'b1;
        step();
        exe_done = 1'b0;
        check("idle_late_done", 32'(resp_valid), 32'd0);
        issue(STORE, 5'd4, 5'd0, 5'd0, 32'h0);
        check("to_no_write", out_data, 32'h1234);
        take_resp("to_no_write");

        // reset pulsed while waiting on the execution unit
        issue(6'b000001, 5'd2, 5'd2, 5'd2, 32'h0);
        exe_ready = 1'b1;
        step();
        exe_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_out_data", out_data, 32'd0);
        check("mid_rst_exe_a", exe_a, 32'd0);
        check("mid_rst_exe_b", exe_b, 32'd0);
        check("mid_rst_exe_valid", 32'(exe_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        issue(STORE, 5'd2, 5'd0, 5'd0, 32'h0);
        check("post_rst_r2", out_data, 32'd0);
        take_resp("post_rst_st");
        issue(LOADI, 5'd0, 5'd0, 5'd7, 32'ha5a5_5a5a);
        check("post_rst_ldi", out_data, 32'ha5a5_5a5a);
        take_resp("post_rst_ldi");
        issue(STORE, 5'd7, 5'd0, 5'd0, 32'h0);
        check("post_rst_r7", out_data, 32'ha5a5_5a5a);
        take_resp("post_rst_r7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
